// File: rtl/lsu_mem_ctrl.sv
// Memory-side load/store responder: runs one data-memory access per instruction,
// stalls the core until it completes and returns lane-aligned, extended load data.
`timescale 1ns/1ps
module lsu_mem_ctrl #(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned ADDR_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [4:0]        memi,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic              stall,
   output logic [31:0]       rdata,
   output logic              misalign,
   output logic              illegal,
   output logic              bus_err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_be,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ready,
   input  logic              mem_rvalid,
   input  logic [31:0]       mem_rdata,
   output logic [1:0]        o_dbg_state
);

   // Handshake: mem_req with mem_we/addr/be/wdata stays asserted and stable until a
   // cycle with mem_ready=1, which transfers the request. Read data is taken only in
   // WAIT_R on a cycle with mem_rvalid=1, so never in the same cycle as mem_ready.

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_REQ    = 2'd1,
      S_WAIT_R = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   localparam int unsigned      CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam bit               TO_EN    = (TIMEOUT != 0);

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [2:0]        r_f3;
   logic [1:0]        r_off;
   logic [31:0]       r_rdata;
   logic              r_misalign;
   logic              r_illegal;
   logic              r_bus_err;
   logic              r_mem_req;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [3:0]        r_mem_be;
   logic [31:0]       r_mem_wdata;

   logic              w_load;
   logic              w_store;
   logic              w_act;
   logic [2:0]        w_f3;
   logic              w_f3_ok;
   logic              w_illegal;
   logic              w_misalign;
   logic [3:0]        w_be;
   logic [31:0]       w_wdata;
   logic [7:0]        w_byte;
   logic [15:0]       w_half;
   logic [31:0]       w_load_data;
   logic              w_expired;

   assign w_load  = memi[4];
   assign w_store = memi[3];
   assign w_f3    = memi[2:0];
   assign w_act   = w_load | w_store;

   // Request decode, evaluated while IDLE.
   always_comb begin
      w_f3_ok    = 1'b0;
      w_illegal  = 1'b0;
      w_misalign = 1'b0;
      w_be       = 4'b1111;
      w_wdata    = 32'h0;
      if (w_store)
         w_f3_ok = w_f3 inside {3'b000, 3'b001, 3'b010};
      else
         w_f3_ok = w_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      w_illegal  = w_act & ((w_load & w_store) | ~w_f3_ok);
      w_misalign = w_act & ~w_illegal &
                   (((w_f3[1:0] == 2'b01) & addr[0]) |
                    ((w_f3[1:0] == 2'b10) & (addr[1:0] != 2'b00)));
      if (w_store) begin
         case (w_f3[1:0])
            2'b00: begin
               w_be    = 4'b0001 << addr[1:0];
               w_wdata = {4{wdata[7:0]}};
            end
            2'b01: begin
               w_be    = 4'b0011 << {addr[1], 1'b0};
               w_wdata = {2{wdata[15:0]}};
            end
            default: begin
               w_be    = 4'b1111;
               w_wdata = wdata;
            end
         endcase
      end
   end

   // Lane select and extension of the returned word, from the registered request.
   always_comb begin
      w_byte      = 8'h0;
      w_half      = 16'h0;
      w_load_data = mem_rdata;
      case (r_off)
         2'b00:   w_byte = mem_rdata[7:0];
         2'b01:   w_byte = mem_rdata[15:8];
         2'b10:   w_byte = mem_rdata[23:16];
         default: w_byte = mem_rdata[31:24];
      endcase
      w_half = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (r_f3)
         3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
         3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
         3'b100:  w_load_data = {24'h0, w_byte};
         3'b101:  w_load_data = {16'h0, w_half};
         default: w_load_data = mem_rdata;
      endcase
   end

   assign w_expired = TO_EN && (r_cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_f3        <= 3'b000;
         r_off       <= 2'b00;
         r_rdata     <= 32'h0;
         r_misalign  <= 1'b0;
         r_illegal   <= 1'b0;
         r_bus_err   <= 1'b0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_be    <= 4'b0000;
         r_mem_wdata <= 32'h0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_act) begin
                  if (w_illegal) begin
                     r_illegal <= 1'b1;
                     r_state   <= S_DONE;
                  end else if (w_misalign) begin
                     r_misalign <= 1'b1;
                     r_state    <= S_DONE;
                  end else begin
                     r_mem_req   <= 1'b1;
                     r_mem_we    <= w_store;
                     r_mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
                     r_mem_be    <= w_be;
                     r_mem_wdata <= w_wdata;
                     r_f3        <= w_f3;
                     r_off       <= addr[1:0];
                     r_cnt       <= '0;
                     r_state     <= S_REQ;
                  end
               end
            end
            S_REQ: begin
               if (mem_ready) begin
                  r_mem_req <= 1'b0;
                  r_cnt     <= '0;
                  r_state   <= r_mem_we ? S_DONE : S_WAIT_R;
               end else if (w_expired) begin
                  r_bus_err <= 1'b1;
                  r_mem_req <= 1'b0;
                  r_state   <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_WAIT_R: begin
               if (mem_rvalid) begin
                  r_rdata <= w_load_data;
                  r_state <= S_DONE;
               end else if (w_expired) begin
                  r_bus_err <= 1'b1;
                  r_state   <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DONE: begin
               r_misalign <= 1'b0;
               r_illegal  <= 1'b0;
               r_bus_err  <= 1'b0;
               r_state    <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign stall       = ((r_state == S_IDLE) & w_act) | (r_state == S_REQ) | (r_state == S_WAIT_R);
   assign rdata       = r_rdata;
   assign misalign    = r_misalign;
   assign illegal     = r_illegal;
   assign bus_err     = r_bus_err;
   assign mem_req     = r_mem_req;
   assign mem_we      = r_mem_we;
   assign mem_addr    = r_mem_addr;
   assign mem_be      = r_mem_be;
   assign mem_wdata   = r_mem_wdata;
   assign o_dbg_state = r_state;

endmodule
